// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - core-to-ring NIC with single-entry in/out channel buffers
// Optional macro CARDINAL_NIC_OUT_FLUSH_EN: writing 1 to the out-status register discards the pending packet.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [ADDR_WIDTH-1:0] A_IN_BUF     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_IN_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_OUT_STATUS = ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] r_in_buf;
    logic [DATA_WIDTH-1:0] r_out_buf;
    logic                  r_in_full;
    logic                  r_out_full;
    logic [DATA_WIDTH-1:0] r_d_out;

    logic w_rd;
    logic w_wr;
    logic w_flush;
    logic w_send;
    logic w_capture;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn & nicWrEn;

`ifdef CARDINAL_NIC_OUT_FLUSH_EN
    assign w_flush = w_wr & (addr == A_OUT_STATUS) & d_in[0];
`else
    assign w_flush = 1'b0;
`endif

    // A packet leaves only on the router's current VC polarity; a flush suppresses it.
    assign w_send    = r_out_full & net_ro & (r_out_buf[VC_BIT] == net_polarity) & ~w_flush;
    assign w_capture = net_si & ~r_in_full;

    assign net_so = w_send;
    assign net_do = r_out_buf;
    assign net_ri = ~r_in_full;
    assign d_out  = r_d_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_buf   <= '0;
            r_out_buf  <= '0;
            r_in_full  <= 1'b0;
            r_out_full <= 1'b0;
            r_d_out    <= '0;
        end else begin
            // Capture requires an empty buffer, so it never collides with a draining read.
            if (w_capture) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_rd && (addr == A_IN_BUF) && r_in_full) begin
                r_in_full <= 1'b0;
            end

            if (w_send || w_flush) begin
                r_out_full <= 1'b0;
            end else if (w_wr && (addr == A_OUT_BUF) && !r_out_full) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end

            if (w_rd) begin
                case (addr)
                    A_IN_BUF:     r_d_out <= r_in_buf;
                    A_IN_STATUS:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_in_full};
                    A_OUT_BUF:    r_d_out <= r_out_buf;
                    A_OUT_STATUS: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_out_full};
                    default:      r_d_out <= r_d_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - directed self-checking bench for cardinal_nic
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int n_pass  = 0;
    int n_total = 0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        step();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        step();
        nicEn = 1'b0;
    endtask

    task automatic push(input logic [63:0] p);
        net_si = 1'b1; net_di = p;
        step();
        net_si = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = 2'd0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("reset_net_ri", {63'b0, net_ri}, 64'd1);
        check("reset_net_so", {63'b0, net_so}, 64'd0);
        check("reset_net_do", net_do, 64'd0);
        check("reset_d_out", d_out, 64'd0);
        rd(2'd3);
        check("reset_out_status", d_out, 64'd0);

        // VC-gated send
        net_ro = 1'b1; net_polarity = 1'b0;
        wr(2'd2, 64'h8000_0000_0000_00AB);
        check("vc_mismatch_so", {63'b0, net_so}, 64'd0);
        check("vc_hold_do", net_do, 64'h8000_0000_0000_00AB);
        rd(2'd3);
        check("vc_held_full", d_out, 64'd1);
        net_polarity = 1'b1;
        #1;
        check("vc_match_so", {63'b0, net_so}, 64'd1);
        check("vc_match_do", net_do, 64'h8000_0000_0000_00AB);
        step();
        check("send_one_cycle", {63'b0, net_so}, 64'd0);
        rd(2'd3);
        check("after_send_status", d_out, 64'd0);
        step();
        check("d_out_holds", d_out, 64'd0);

        // Back-to-back writes while router busy
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'd2, 64'h1);
        wr(2'd2, 64'h2);
        rd(2'd2);
        check("second_write_dropped", d_out, 64'h1);
        rd(2'd3);
        check("out_full_set", d_out, 64'd1);

        // Write during the send edge is ignored
        net_ro = 1'b1;
        #1;
        check("send_bit63_zero", {63'b0, net_so}, 64'd1);
        wr(2'd2, 64'h3);
        net_ro = 1'b0;
        rd(2'd3);
        check("write_on_send_status", d_out, 64'd0);
        rd(2'd2);
        check("write_on_send_buf", d_out, 64'h1);

        // nicEn=0 writes do nothing
        nicEn = 1'b0; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'hAA;
        step();
        nicWrEn = 1'b0;
        rd(2'd3);
        check("nicen_low_no_write", d_out, 64'd0);

        // Input channel
        push(64'h0000_0000_DEAD_BEEF);
        check("in_full_ri", {63'b0, net_ri}, 64'd0);
        rd(2'd1);
        check("in_status", d_out, 64'd1);
        rd(2'd0);
        check("in_read_data", d_out, 64'h0000_0000_DEAD_BEEF);
        check("in_read_ri", {63'b0, net_ri}, 64'd1);

        // Drain and arrival in the same cycle
        push(64'h11);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0; net_si = 1'b1; net_di = 64'h55;
        step();
        nicEn = 1'b0;
        check("drain_read_data", d_out, 64'h11);
        check("drain_no_capture_ri", {63'b0, net_ri}, 64'd1);
        step();
        net_si = 1'b0;
        check("capture_next_ri", {63'b0, net_ri}, 64'd0);
        rd(2'd0);
        check("capture_next_data", d_out, 64'h55);

        // Protocol violation while full is ignored
        push(64'h66);
        push(64'h77);
        rd(2'd0);
        check("violation_ignored", d_out, 64'h66);
        rd(2'd0);
        check("empty_read_stale", d_out, 64'h66);
        check("empty_read_ri", {63'b0, net_ri}, 64'd1);
        rd(2'd1);
        check("empty_read_status", d_out, 64'd0);

        // Writes to in-side registers are ignored
        wr(2'd0, 64'h99);
        wr(2'd1, 64'h1);
        rd(2'd1);
        check("wr_in_status_ignored", d_out, 64'd0);
        rd(2'd0);
        check("wr_in_buf_ignored", d_out, 64'h66);

        // Out-status write: flush or ignore
        net_ro = 1'b0;
        wr(2'd2, 64'h5);
        wr(2'd3, 64'h0);
        rd(2'd3);
        check("flush_zero_ignored", d_out, 64'd1);
        wr(2'd3, 64'h1);
        rd(2'd3);
`ifdef CARDINAL_NIC_OUT_FLUSH_EN
        check("flush_write", d_out, 64'd0);
        wr(2'd2, 64'h5);
`else
        check("flush_write", d_out, 64'd1);
`endif

        // Reset with a pending packet, full input buffer and nonzero d_out
        push(64'h42);
        rd(2'd2);
        check("pre_reset_d_out", d_out, 64'h5);
        net_ro = 1'b0;
        reset = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'hF0;
        step();
        reset = 1'b1; nicEn = 1'b0; nicWrEn = 1'b0;
        check("mid_reset_d_out", d_out, 64'd0);
        check("mid_reset_net_do", net_do, 64'd0);
        check("mid_reset_ri", {63'b0, net_ri}, 64'd1);
        net_ro = 1'b1;
        #1;
        check("mid_reset_so", {63'b0, net_so}, 64'd0);
        rd(2'd3);
        check("mid_reset_out_status", d_out, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
